// File: rtl/if_stage_fq.sv
// Instruction fetch stage with a multi-entry fetch queue and up to MAX_OUT
// in-flight requests on the SRAM-like addr_ok/data_ok interface.
module if_stage_fq #(
    parameter logic [31:0] RESET_PC = 32'h1c000000,
    parameter int          FQ_DEPTH = 4,
    parameter int          MAX_OUT  = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        inst_sram_req,
    output logic        inst_sram_wr,
    output logic [1:0]  inst_sram_size,
    output logic [3:0]  inst_sram_wstrb,
    output logic [31:0] inst_sram_addr,
    output logic [31:0] inst_sram_wdata,
    input  logic        inst_sram_addr_ok,
    input  logic        inst_sram_data_ok,
    input  logic [31:0] inst_sram_rdata,
    input  logic        ID_allow_in,
    input  logic [32:0] BR_BUS,
    output logic        IFreg_valid,
    output logic [31:0] IFreg_pc,
    output logic [31:0] IFreg_inst,
    output logic        IFreg_adef
);
    localparam int QW = $clog2(FQ_DEPTH);
    localparam int CW = $clog2(FQ_DEPTH + 1);
    localparam int PW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam int OW = $clog2(MAX_OUT + 1);

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        adef;
    } fq_entry_t;

    logic [31:0]                   fetch_pc;
    logic [MAX_OUT-1:0][31:0]      pend_pc;
    logic [PW-1:0]                 pp_wr, pp_rd;
    logic [OW-1:0]                 out_cnt, dis_cnt, out_nxt;
    fq_entry_t [FQ_DEPTH-1:0]      fq;
    logic [QW-1:0]                 q_head, q_tail;
    logic [CW-1:0]                 q_count;
    logic                          adef_done;

    logic        br_taken;
    logic [31:0] br_target;
    logic        aligned, hs, rsp, rsp_drop, rsp_push, adef_push, push, pop;
    logic [31:0] credits;
    fq_entry_t   push_entry, head;

    function automatic logic [PW-1:0] pp_next(input logic [PW-1:0] p);
        return (p == PW'(MAX_OUT - 1)) ? '0 : p + 1'b1;
    endfunction

    assign {br_taken, br_target} = BR_BUS;
    assign aligned = (fetch_pc[1:0] == 2'b00);

    // Queue slots already promised to in-flight requests; stale ones hold no slot.
    assign credits = 32'(q_count) + 32'(out_cnt) - 32'(dis_cnt);

    assign inst_sram_req = ~reset & aligned & ~br_taken
                         & (out_cnt < OW'(MAX_OUT)) & (credits < 32'(FQ_DEPTH));
    assign inst_sram_wr    = 1'b0;
    assign inst_sram_size  = 2'b10;
    assign inst_sram_wstrb = 4'b0000;
    assign inst_sram_addr  = fetch_pc;
    assign inst_sram_wdata = 32'h0;

    assign hs        = inst_sram_req & inst_sram_addr_ok;
    assign rsp       = inst_sram_data_ok & (out_cnt != '0);
    assign rsp_drop  = rsp & (dis_cnt != '0);
    assign rsp_push  = rsp & (dis_cnt == '0) & ~br_taken;
    assign adef_push = ~aligned & ~adef_done & ~br_taken & (out_cnt == '0)
                     & (dis_cnt == '0) & (q_count != CW'(FQ_DEPTH));
    assign push      = rsp_push | adef_push;
    assign pop       = ID_allow_in & IFreg_valid & ~br_taken;
    assign out_nxt   = out_cnt + OW'(hs) - OW'(rsp);

    assign push_entry = rsp_push ? '{pc: pend_pc[pp_rd], inst: inst_sram_rdata, adef: 1'b0}
                                 : '{pc: fetch_pc, inst: 32'h0, adef: 1'b1};

    assign head        = fq[q_head];
    assign IFreg_valid = (q_count != '0);
    assign IFreg_pc    = head.pc;
    assign IFreg_inst  = head.inst;
    assign IFreg_adef  = head.adef;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc  <= RESET_PC;
            pend_pc   <= '0;
            pp_wr     <= '0;
            pp_rd     <= '0;
            out_cnt   <= '0;
            dis_cnt   <= '0;
            fq        <= '0;
            q_head    <= '0;
            q_tail    <= '0;
            q_count   <= '0;
            adef_done <= 1'b0;
        end else begin
            out_cnt <= out_nxt;
            if (hs) begin
                pend_pc[pp_wr] <= fetch_pc;
                pp_wr          <= pp_next(pp_wr);
            end
            if (rsp)
                pp_rd <= pp_next(pp_rd);

            if (br_taken) begin
                // Everything still in flight after this cycle belongs to the old path.
                fetch_pc  <= br_target;
                dis_cnt   <= out_nxt;
                adef_done <= 1'b0;
                q_head    <= '0;
                q_tail    <= '0;
                q_count   <= '0;
            end else begin
                if (hs)
                    fetch_pc <= fetch_pc + 32'd4;
                if (rsp_drop)
                    dis_cnt <= dis_cnt - 1'b1;
                if (adef_push)
                    adef_done <= 1'b1;
                if (push) begin
                    fq[q_tail] <= push_entry;
                    q_tail     <= q_tail + 1'b1;
                end
                if (pop)
                    q_head <= q_head + 1'b1;
                q_count <= q_count + CW'(push) - CW'(pop);
            end
        end
    end
endmodule
